// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB/APB constants, bridge states and strobe helper
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  // Larger-than-word sizes collapse to a full-word strobe on the 32-bit APB side.
  function automatic logic [3:0] size_to_strb(input logic [2:0] hsize, input logic [1:0] addr_lo);
    case (hsize)
      3'd0:    size_to_strb = 4'b0001 << addr_lo;
      3'd1:    size_to_strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: size_to_strb = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/ahb_apb_decoder.sv
// rtl/ahb_apb_decoder.sv - combinational address decode into completer select, index and miss
module ahb_apb_decoder
  import ahb_apb_pkg::*;
#(
  parameter int                    NUM_SLAVES  = 8,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    REGION_BITS = 8
) (
  input  logic [ADDR_WIDTH-1:0] haddr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [3:0]            idx,
  output logic                  miss
);

  logic [ADDR_WIDTH-1:0] region;

  assign region = (haddr - BASE_ADDR) >> REGION_BITS;
  assign idx    = region[3:0];
  assign miss   = (haddr < BASE_ADDR) || (region >= ADDR_WIDTH'(NUM_SLAVES));

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      sel[i] = !miss && (region == ADDR_WIDTH'(i));
  end

endmodule

// File: rtl/ahb_apb_bridge.sv
// rtl/ahb_apb_bridge.sv - AHB subordinate to APB4 requester bridge with decode and timeout
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int                    NUM_SLAVES  = 8,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    REGION_BITS = 8,
  parameter int                    TIMEOUT     = 255
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic                             HSEL,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  input  logic                             HWRITE,
  input  logic [2:0]                       HSIZE,
  input  logic [3:0]                       HPROT,
  input  logic [DATA_WIDTH-1:0]            HWDATA,
  input  logic                             HREADY,
  output logic                             HREADYOUT,
  output logic                             HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [3:0]                       PSTRB,
  output logic [2:0]                       PPROT,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                  state;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic [3:0]              idx_q;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic [3:0]              dec_idx;
  logic                    dec_miss;
  logic                    accept;
  logic                    timed_out;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    unused_hprot;

  assign unused_hprot = ^HPROT[3:2];

  ahb_apb_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .REGION_BITS(REGION_BITS)
  ) u_decoder (
    .haddr(HADDR),
    .sel  (dec_sel),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  assign accept = HSEL && HREADY && HREADYOUT &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  // Only the registered completer's returns are looked at; all others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  assign HREADYOUT = (state == ST_IDLE) || (state == ST_ERR2);
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign PSEL      = ((state == ST_SETUP) || (state == ST_ACCESS)) ? sel_q : '0;
  assign PENABLE   = (state == ST_ACCESS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= ST_IDLE;
      sel_q  <= '0;
      idx_q  <= '0;
      cnt    <= '0;
      HRDATA <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
      PPROT  <= '0;
    end else begin
      case (state)
        // ERR2 already drives HREADYOUT high, so it takes new transfers like IDLE.
        ST_IDLE, ST_ERR2: begin
          if (!accept) begin
            state <= ST_IDLE;
          end else if (dec_miss) begin
            state <= ST_ERR1;
          end else begin
            state  <= HWRITE ? ST_WDATA : ST_SETUP;
            sel_q  <= dec_sel;
            idx_q  <= dec_idx;
            PADDR  <= HADDR;
            PWRITE <= HWRITE;
            PSTRB  <= HWRITE ? size_to_strb(HSIZE, HADDR[1:0]) : 4'h0;
            PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
          end
        end
        ST_WDATA: begin
          PWDATA <= HWDATA;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          cnt   <= '0;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            cnt <= '0;
            if (sel_err) begin
              state <= ST_ERR1;
            end else begin
              state <= ST_IDLE;
              if (!PWRITE) HRDATA <= sel_rdata;
            end
          end else if (timed_out) begin
            cnt   <= '0;
            state <= ST_ERR1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ERR1: state <= ST_ERR2;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
